// File: rtl/time_display_driver.sv
// Scans an 8-digit common-anode display as "HH-MM-SS" from a per-frame time snapshot.
// Optional digit blinking for the field being set is built only when TIME_DISPLAY_BLINK_EN is defined.
module time_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [2:0] mode,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [2:0]       scan_q, scan_d;
  logic             started_q, started_d;
  logic [4:0]       snap_h_q, snap_h_d;
  logic [5:0]       snap_m_q, snap_m_d;
  logic [5:0]       snap_s_q, snap_s_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [5:0]       val;
  logic [3:0]       tens, ones, digit;
  logic             is_dash, is_ones, blank;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_OFF;
    endcase
  endfunction

  assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    scan_d    = tick ? scan_q + 3'd1 : scan_q;
    started_d = started_q | tick;
    snap_h_d  = snap_h_q;
    snap_m_d  = snap_m_q;
    snap_s_d  = snap_s_q;
    // Capture only at the frame boundary so one frame never mixes two times.
    if (tick && scan_q == 3'd7) begin
      snap_h_d = hrs;
      snap_m_d = min;
      snap_s_d = sec;
    end
  end

`ifdef TIME_DISPLAY_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q + 1'b1;
    phase_d   = phase_q;
    if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      phase_d   = ~phase_q;
    end
    blank = 1'b0;
    if (phase_q) begin
      case (mode)
        3'd1:    blank = (scan_q >= 3'd6);
        3'd2:    blank = (scan_q == 3'd3) || (scan_q == 3'd4);
        3'd3:    blank = (scan_q <= 3'd1);
        default: blank = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (^mode) ^ (BLINK_DIV > 0);
  assign blank      = 1'b0;
`endif

  always_comb begin
    val     = '0;
    is_dash = 1'b0;
    case (scan_q)
      3'd0, 3'd1: val = snap_s_q;
      3'd3, 3'd4: val = snap_m_q;
      3'd6, 3'd7: val = {1'b0, snap_h_q};
      default:    is_dash = 1'b1;
    endcase
    is_ones = (scan_q == 3'd0) || (scan_q == 3'd3) || (scan_q == 3'd6);
    // Largest multiple of ten not above val gives tens; remainder is ones.
    tens = '0;
    ones = val[3:0];
    for (int i = 1; i <= 6; i++) begin
      if (val >= 6'(10 * i)) begin
        tens = 4'(i);
        ones = 4'(val - 6'(10 * i));
      end
    end
    digit = is_ones ? ones : tens;
    an_d  = 8'hFF;
    seg_d = SEG_OFF;
    if (started_q) begin
      an_d = ~(8'd1 << scan_q);
      if (blank)        seg_d = SEG_OFF;
      else if (is_dash) seg_d = SEG_DASH;
      else              seg_d = seg_code(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      scan_q    <= 3'd7;
      started_q <= 1'b0;
      snap_h_q  <= '0;
      snap_m_q  <= '0;
      snap_s_q  <= '0;
      an_q      <= 8'hFF;
      seg_q     <= SEG_OFF;
    end else begin
      cnt_q     <= cnt_d;
      scan_q    <= scan_d;
      started_q <= started_d;
      snap_h_q  <= snap_h_d;
      snap_m_q  <= snap_m_d;
      snap_s_q  <= snap_s_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_time_display_driver.sv
// Self-checking bench for time_display_driver: every cycle compares an/seg/dp against
// a model derived from cycle counts since reset release and the frame-snapshot rule.
module tb_time_display_driver;

`ifdef TIME_DISPLAY_BLINK_EN
  localparam int R = 2;
`else
  localparam int R = 4;
`endif
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] hrs;
  logic [5:0] min;
  logic [5:0] sec;
  logic [2:0] mode;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int snap_h = 0, snap_m = 0, snap_s = 0;

  always #5 clk = ~clk;

  time_display_driver #(.REFRESH_DIV(R), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .hrs(hrs), .min(min), .sec(sec), .mode(mode),
    .an(an), .seg(seg), .dp(dp)
  );

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Display layout reads right to left: SS at slots 0-1, MM at 3-4, HH at 6-7.
  function automatic logic [6:0] slot_seg(input int slot, input int h, input int m, input int s);
    case (slot)
      0: return digit_seg(s % 10);
      1: return digit_seg(s / 10);
      3: return digit_seg(m % 10);
      4: return digit_seg(m / 10);
      6: return digit_seg(h % 10);
      7: return digit_seg(h / 10);
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic bit blanked(input int md, input int slot);
    return (md == 1 && (slot == 6 || slot == 7)) ||
           (md == 2 && (slot == 3 || slot == 4)) ||
           (md == 3 && (slot == 0 || slot == 1));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s n=%0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    int         slot;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    @(posedge clk);
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    if (!rst_n) begin
      n = 0;
      snap_h = 0; snap_m = 0; snap_s = 0;
    end else begin
      n++;
      if (n >= R + 1) begin
        slot  = ((n - 1) / R - 1) % 8;
        e_an  = ~(8'd1 << slot);
        e_seg = slot_seg(slot, snap_h, snap_m, snap_s);
`ifdef TIME_DISPLAY_BLINK_EN
        if ((((n - 1) / BD) % 2) == 1 && blanked(int'(mode), slot)) e_seg = 7'h7F;
`endif
      end
      if (n >= R && ((n - R) % (8 * R)) == 0) begin
        snap_h = int'(hrs); snap_m = int'(min); snap_s = int'(sec);
      end
    end
    #1;
    chk("an", an, e_an);
    chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("dp", {7'b0, dp}, 8'h01);
  endtask

  task automatic run_until(input int target);
    while (n < target) step();
  endtask

  task automatic randomize_inputs();
    hrs  = 5'($urandom_range(0, 31));
    min  = 6'($urandom_range(0, 63));
    sec  = 6'($urandom_range(0, 63));
    mode = 3'($urandom_range(0, 7));
  endtask

  initial begin
    rst_n = 1'b0;
    randomize_inputs();
    repeat (3) begin
      step();
      randomize_inputs();
    end

    // Reference frame 23-59-55, with sec changing mid-frame.
    hrs = 5'd23; min = 6'd59; sec = 6'd55; mode = 3'd0;
    rst_n = 1'b1;
    run_until(4 * R + 1);
    sec = 6'd56;
    run_until(9 * R + 1);

    hrs = 5'd0; min = 6'd0; sec = 6'd0;
    run_until(17 * R + 1);
    hrs = 5'd31; min = 6'd63; sec = 6'($urandom_range(0, 63));
    run_until(25 * R + 1);

    // Fully random inputs every cycle; only frame-boundary values may appear.
    repeat (6 * 8 * R) begin
      randomize_inputs();
      step();
    end

    // Reset for one cycle while scan index 4 is showing.
    while (((n / R) - 1) % 8 != 4) begin
      randomize_inputs();
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (17 * R) begin
      randomize_inputs();
      step();
    end

`ifdef TIME_DISPLAY_BLINK_EN
    hrs = 5'd12; min = 6'd34; sec = 6'd56; mode = 3'd2;
    repeat (8 * BD) step();
    mode = 3'd0;
    repeat (4 * BD) step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
